// File: rtl/k_vector_streamer.sv
// Consumer side of the packed K-constant vector: snapshots a completed vector,
// unpacks the bit-reversed words and streams them round 0 upward over valid/ready.
module k_vector_streamer #(
    parameter int K_LENGTH        = 64,
    parameter int K_VECTOR_LENGTH = 2048
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        k_vector_complete,
    input  logic [K_VECTOR_LENGTH-1:0]  k_vector,
    input  logic                        k_ready,
    input  logic                        abort,
    output logic                        k_valid,
    output logic [31:0]                 k_value,
    output logic [$clog2(K_LENGTH)-1:0] k_round,
    output logic                        busy,
    output logic                        stream_complete
);

    localparam int RW = $clog2(K_LENGTH);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t                     state, state_next;
    logic [K_VECTOR_LENGTH-1:0] shadow, shadow_next;
    logic                       valid_next, busy_next, done_next;
    logic [31:0]                value_next;
    logic [RW-1:0]              round_next, round_inc;
    logic [K_LENGTH-1:0][31:0]  words;
    logic                       xfer, last;

    // Undo the loader's packing: shadow bit 32i+b carries K[i][31-b].
    for (genvar i = 0; i < K_LENGTH; i++) begin : g_word
        for (genvar b = 0; b < 32; b++) begin : g_bit
            assign words[i][31-b] = shadow[32*i+b];
        end
    end

    assign xfer      = k_valid && k_ready;
    assign last      = (k_round == RW'(K_LENGTH-1));
    assign round_inc = k_round + RW'(1);

    always_comb begin
        state_next  = state;
        shadow_next = shadow;
        valid_next  = k_valid;
        value_next  = k_value;
        round_next  = k_round;
        busy_next   = busy;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start && k_vector_complete) begin
                    shadow_next = k_vector;
                    round_next  = '0;
                    busy_next   = 1'b1;
                    state_next  = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                    round_next = '0;
                    state_next = IDLE;
                end else begin
                    value_next = words[0];
                    round_next = '0;
                    valid_next = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                // abort wins over a transfer in the same cycle
                if (abort) begin
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                    round_next = '0;
                    state_next = IDLE;
                end else if (xfer) begin
                    if (last) begin
                        valid_next = 1'b0;
                        round_next = '0;
                        busy_next  = 1'b0;
                        state_next = DONE;
                    end else begin
                        round_next = round_inc;
                        value_next = words[round_inc];
                    end
                end
            end
            DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            shadow          <= '0;
            k_valid         <= 1'b0;
            k_value         <= '0;
            k_round         <= '0;
            busy            <= 1'b0;
            stream_complete <= 1'b0;
        end else begin
            state           <= state_next;
            shadow          <= shadow_next;
            k_valid         <= valid_next;
            k_value         <= value_next;
            k_round         <= round_next;
            busy            <= busy_next;
            stream_complete <= done_next;
        end
    end

endmodule

// File: tb/tb_k_vector_streamer.sv
// Directed bench for k_vector_streamer: a per-cycle vector table for the start/
// handshake basics, then hand-written full streams for the multi-cycle cases.
module tb_k_vector_streamer;

    localparam int KL = 64;
    localparam int KV = 2048;

    logic          clock = 1'b0;
    logic          reset;
    logic          start, k_vector_complete, k_ready, abort;
    logic [KV-1:0] k_vector;
    logic          k_valid, busy, stream_complete;
    logic [31:0]   k_value;
    logic [5:0]    k_round;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] K [0:KL-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        logic        st, cmpl, rdy, ab;
        logic        e_valid;
        logic [5:0]  e_round;
        logic [31:0] e_value;
        logic        e_busy, e_done;
    } vec_t;

    vec_t tbl [13];

    k_vector_streamer #(.K_LENGTH(KL), .K_VECTOR_LENGTH(KV)) dut (
        .clock(clock), .reset(reset), .start(start),
        .k_vector_complete(k_vector_complete), .k_vector(k_vector),
        .k_ready(k_ready), .abort(abort), .k_valid(k_valid), .k_value(k_value),
        .k_round(k_round), .busy(busy), .stream_complete(stream_complete)
    );

    always #5 clock = ~clock;

    function automatic logic [KV-1:0] pack_k();
        logic [KV-1:0] v;
        v = '0;
        for (int i = 0; i < KL; i++)
            for (int b = 0; b < 32; b++)
                v[32*i+b] = K[i][31-b];
        return v;
    endfunction

    function automatic vec_t mk(logic st, logic cmpl, logic rdy, logic ab, logic ev,
                                logic [5:0] er, logic [31:0] eval, logic eb, logic ed);
        vec_t r;
        r.st = st; r.cmpl = cmpl; r.rdy = rdy; r.ab = ab;
        r.e_valid = ev; r.e_round = er; r.e_value = eval; r.e_busy = eb; r.e_done = ed;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {valid, busy, done, round} all idle-quiet
    task automatic chk_quiet(input string name);
        chk(name, {k_valid, busy, stream_complete, k_round}, 64'd0);
    endtask

    task automatic do_start();
        start = 1'b1; k_vector_complete = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("load_state", {k_valid, busy}, {1'b0, 1'b1});
        @(negedge clock);
    endtask

    // mode 0: k_ready held high; mode 1: k_ready 1,0,0 repeating with start held high.
    task automatic stream_words(input int mode, input int abort_at, input int zero_at, input int rst_at);
        int nxt = 0;
        int cyc = 0;
        while (nxt < KL) begin
            if (cyc > 400) begin
                chk("stream_timeout", 64'(nxt), 64'(KL));
                return;
            end
            chk($sformatf("word%0d", nxt), {k_valid, k_round, k_value}, {1'b1, 6'(nxt), K[nxt]});
            if (nxt == zero_at) begin
                k_vector = '0; k_vector_complete = 1'b0;
            end
            if (nxt == abort_at) begin
                abort = 1'b1; k_ready = 1'b1;
                @(negedge clock);
                abort = 1'b0; k_ready = 1'b0;
                chk("abort_quiet", {k_valid, busy, stream_complete, k_round}, 64'd0);
                repeat (3) begin
                    @(negedge clock);
                    chk("abort_no_done", {k_valid, busy, stream_complete}, 64'd0);
                end
                return;
            end
            if (nxt == rst_at) begin
                k_ready = 1'b0;
                #2 reset = 1'b0;
                #1 chk("async_reset", {k_valid, k_value, k_round, busy, stream_complete}, 64'd0);
                @(negedge clock);
                chk("reset_hold", {k_valid, k_value, k_round, busy, stream_complete}, 64'd0);
                reset = 1'b1;
                return;
            end
            k_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            start   = (mode == 1);
            @(negedge clock);
            if (k_ready) nxt++;
            cyc++;
        end
        start = 1'b0; k_ready = 1'b0;
        chk("after_last", {k_valid, busy, stream_complete, k_round}, 64'd0);
        @(negedge clock);
        chk("done_pulse", {k_valid, busy, stream_complete}, {1'b0, 1'b0, 1'b1});
        @(negedge clock);
        chk("done_clear", {k_valid, busy, stream_complete}, 64'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; k_vector_complete = 1'b0; k_ready = 1'b0; abort = 1'b0;
        k_vector = pack_k();

        //            st cm rd ab  v  round value  busy done
        tbl[0]  = mk(1, 0, 0, 0,  0, 6'd0, 32'h0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 1,  0, 6'd0, 32'h0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 0,  0, 6'd0, 32'h0, 1, 0);
        tbl[3]  = mk(1, 1, 1, 0,  1, 6'd0, K[0],  1, 0);
        tbl[4]  = mk(0, 1, 0, 0,  1, 6'd0, K[0],  1, 0);
        tbl[5]  = mk(0, 1, 1, 0,  1, 6'd1, K[1],  1, 0);
        tbl[6]  = mk(0, 1, 1, 0,  1, 6'd2, K[2],  1, 0);
        tbl[7]  = mk(0, 1, 0, 0,  1, 6'd2, K[2],  1, 0);
        tbl[8]  = mk(0, 1, 1, 1,  0, 6'd0, 32'h0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0,  0, 6'd0, 32'h0, 0, 0);
        tbl[10] = mk(1, 1, 0, 0,  0, 6'd0, 32'h0, 1, 0);
        tbl[11] = mk(0, 1, 0, 1,  0, 6'd0, 32'h0, 0, 0);
        tbl[12] = mk(0, 1, 0, 0,  0, 6'd0, 32'h0, 0, 0);

        repeat (2) @(negedge clock);
        chk("reset_state", {k_valid, k_value, k_round, busy, stream_complete}, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        foreach (tbl[i]) begin
            start = tbl[i].st; k_vector_complete = tbl[i].cmpl;
            k_ready = tbl[i].rdy; abort = tbl[i].ab;
            @(negedge clock);
            // k_value is only meaningful while k_valid is high
            chk($sformatf("vec%0d", i),
                {k_valid, k_round, busy, stream_complete, tbl[i].e_valid ? k_value : 32'h0},
                {tbl[i].e_valid, tbl[i].e_round, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_value});
        end
        start = 1'b0; k_ready = 1'b0; abort = 1'b0;
        @(negedge clock);

        // continuous ready, then the stalled pattern
        do_start(); stream_words(0, -1, -1, -1);
        do_start(); stream_words(1, -1, -1, -1);

        // start without a complete vector is ignored
        k_vector_complete = 1'b0; start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk($sformatf("no_cmpl%0d", c), {k_valid, busy}, 64'd0);
        end
        start = 1'b0;
        do_start(); stream_words(0, -1, -1, -1);

        // source overwritten mid-stream
        do_start(); stream_words(0, -1, 10, -1);
        k_vector = pack_k(); k_vector_complete = 1'b1;

        // abort alongside a transfer, then restart
        do_start(); stream_words(0, 20, -1, -1);
        chk_quiet("abort_idle");
        do_start(); stream_words(0, -1, -1, -1);

        // asynchronous reset mid-stream, then restart
        do_start(); stream_words(0, -1, -1, 30);
        chk_quiet("post_reset");
        do_start(); stream_words(0, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
